glb_dummy_end: RTL
==================

# glb_dummy_end

East terminus of the global buffer tile chain, sitting after the last glb tile. Sinks processor, configuration and SRAM-configuration traffic that no tile claimed, and returns deterministic poison read responses westward so that no read to an unmapped address hangs. Counts every unclaimed transaction in saturating counters and raises a sticky error flag for debug.

## Interface
Parameters:
- RD_LATENCY, 2, cycles from unclaimed proc rd_en to poison rdrs; legal 1..4
- CNT_WIDTH, 16, width of each unclaimed-transaction counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- proc_packet_w2e_wsti  in  packet_t  wr/rdrq from last tile; rdrs field ignored
- proc_packet_e2w_wsto  out  packet_t  rdrs poison responses; wr and rdrq fields tied 0
- if_cfg_wst_s  cfg_ifc.slave  AXI_ADDR_WIDTH/AXI_DATA_WIDTH glb config from last tile
- if_sram_cfg_wst_s  cfg_ifc.slave  GLB_ADDR_WIDTH/CGRA_CFG_DATA_WIDTH sram config from last tile
- strm_packet_e2w_wsto  out  packet_t  tied 0
- pc_packet_e2w_wsto  out  rd_packet_t  tied 0
- err_clr  in  1  clears counters and err_flag
- unmapped_proc_wr_cnt  out  CNT_WIDTH  dropped proc writes
- unmapped_proc_rd_cnt  out  CNT_WIDTH  poisoned proc reads
- unmapped_cfg_cnt  out  CNT_WIDTH  unclaimed cfg + sram cfg reads and writes
- err_flag  out  1  sticky, set by any unclaimed transaction

## Operation
- Proc write (wr.wr_en=1): data discarded; unmapped_proc_wr_cnt increments.
- Proc read (rdrq.rd_en=1): enters RD_LATENCY-deep valid shift pipe; on exit drive rdrs.rd_data_valid=1, rdrs.rd_data = PROC_POISON_WORD replicated to BANK_DATA_WIDTH (64b: 64'hDEAD_DEAD_DEAD_DEAD); unmapped_proc_rd_cnt increments on acceptance. Back-to-back reads every cycle produce back-to-back responses; no stall.
- Cfg read (rd_en=1, rd_clk_en ignored): next cycle rd_data=CFG_POISON_WORD (32'hDEAD_BEEF), rd_data_valid=1 for exactly one cycle; otherwise rd_data=0, valid=0. Same for sram cfg interface (poison truncated to CGRA_CFG_DATA_WIDTH).
- Cfg/sram cfg write (wr_en=1): discarded, counted.
- unmapped_cfg_cnt adds count of {cfg wr, cfg rd, sram wr, sram rd} asserted that cycle (0..4).
- Counters saturate at all-ones; never wrap.
- err_flag sets on any increment; held until err_clr or reset.
- err_clr with a simultaneous event: counters load the event increment (e.g. 1), err_flag=1 (event wins for flag).
- Proc wr and rd in same cycle: both counted independently.

## Timing
- Reset values (next edge with reset=0): all outputs 0, pipe flushed, counters 0, err_flag 0.
- Reset mid-operation: in-flight poison responses dropped; none emerge after reset release.
- Proc rd latency exactly RD_LATENCY edges; cfg rd latency 1 edge.
- Counters and err_flag update 1 edge after the event.
- All outputs registered except the tied-0 fields.

## Structure
- PROC_POISON_WORD (16'hDEAD) and CFG_POISON_WORD (32'hDEAD_BEEF) live in global_buffer_param; packet_t/rd_packet_t from global_buffer_pkg, unchanged.
- One sub-module: glb_sat_counter (CNT_WIDTH, 3-bit increment input, clr, saturation), instantiated three times.

## Test plan
- Reset, single proc rd_en at cycle 10, RD_LATENCY=2 -> rdrs valid at 12 only, data 64'hDEAD_DEAD_DEAD_DEAD, rd_cnt=1, err_flag=1.
- 8 consecutive proc reads -> 8 consecutive valid responses, rd_cnt=8; repeat with RD_LATENCY=1 and 4.
- cfg rd + sram cfg rd + cfg wr + sram wr same cycle -> both rd_data_valid next cycle (32'hDEAD_BEEF), cfg_cnt=4.
- Force 65540 proc writes, CNT_WIDTH=16 -> wr_cnt holds 16'hFFFF.
- err_clr coincident with proc wr -> wr_cnt=1, err_flag=1; err_clr alone -> all 0.
- Proc read at cycle 10, reset=0 at cycle 11 -> no rdrs valid ever, counters 0.

Source files
------------

// File: rtl/glb_dummy_end_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glb_dummy_end_pkg
// Purpose  : Shared widths, poison words and packet types for the global
//            buffer east terminus. Mirrors the global_buffer_param and
//            global_buffer_pkg definitions used by the glb tiles.
// Contents : BANK/GLB/AXI/CGRA widths, PROC_POISON_WORD, CFG_POISON_WORD,
//            wr/rdrq/rdrs packet structs, packet_t, rd_packet_t,
//            count_ones4() helper.
// Revision : 1.0 - initial release
// ============================================================================
package glb_dummy_end_pkg;

   localparam int BANK_DATA_WIDTH     = 64;
   localparam int GLB_ADDR_WIDTH      = 19;
   localparam int AXI_ADDR_WIDTH      = 12;
   localparam int AXI_DATA_WIDTH      = 32;
   localparam int CGRA_CFG_ADDR_WIDTH = 8;
   localparam int CGRA_CFG_DATA_WIDTH = 32;

   localparam logic [15:0] PROC_POISON_WORD = 16'hDEAD;
   localparam logic [31:0] CFG_POISON_WORD  = 32'hDEAD_BEEF;

   typedef struct packed {
      logic                         wr_en;
      logic [BANK_DATA_WIDTH/8-1:0] wr_strb;
      logic [GLB_ADDR_WIDTH-1:0]    wr_addr;
      logic [BANK_DATA_WIDTH-1:0]   wr_data;
   } wr_packet_t;

   typedef struct packed {
      logic                      rd_en;
      logic [GLB_ADDR_WIDTH-1:0] rd_addr;
   } rdrq_packet_t;

   typedef struct packed {
      logic [BANK_DATA_WIDTH-1:0] rd_data;
      logic                       rd_data_valid;
   } rdrs_packet_t;

   typedef struct packed {
      wr_packet_t   wr;
      rdrq_packet_t rdrq;
      rdrs_packet_t rdrs;
   } packet_t;

   typedef struct packed {
      rdrq_packet_t rdrq;
      rdrs_packet_t rdrs;
   } rd_packet_t;

   // Number of asserted bits in a 4-bit event vector (0..4).
   function automatic logic [2:0] count_ones4(input logic [3:0] v);
      count_ones4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_ifc.sv
`default_nettype none
// ============================================================================
// Module   : cfg_ifc
// Purpose  : Configuration read/write interface between glb tiles.
// Ports    : master drives wr_*/rd_en/rd_clk_en/rd_addr, slave returns
//            rd_data/rd_data_valid.
// Revision : 1.0 - initial release
// ============================================================================
interface cfg_ifc #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  wr_en;
   logic                  wr_clk_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic                  rd_clk_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;

   modport master (
      output wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en, rd_addr,
      input  rd_data, rd_data_valid
   );

   modport slave (
      input  wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en, rd_addr,
      output rd_data, rd_data_valid
   );
endinterface
`default_nettype wire

// File: rtl/glb_dummy_end_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : glb_sat_counter
// Purpose  : Saturating up-counter with a 0..7 increment per cycle and a
//            synchronous clear. When clear and an increment coincide, the
//            counter loads the increment.
// Ports    : clk, reset (sync, active-low), clr_i, inc_i[2:0],
//            cnt_o[CNT_WIDTH-1:0] (registered)
// Revision : 1.0 - initial release
// ============================================================================
module glb_sat_counter #(
   parameter int CNT_WIDTH = 16   // must be >= 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr_i,
   input  logic [2:0]           inc_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, base;
   logic [CNT_WIDTH:0]   sum;

   // One extra sum bit is enough to detect overflow: base + 7 < 2^(W+1).
   always_comb begin
      base  = clr_i ? '0 : cnt_q;
      sum   = {1'b0, base} + {{(CNT_WIDTH-2){1'b0}}, inc_i};
      cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/glb_dummy_end.sv
`default_nettype none
// ============================================================================
// Module   : glb_dummy_end
// Purpose  : East terminus of the glb tile chain. Sinks unclaimed proc, cfg
//            and sram-cfg traffic, answers reads with poison data so nothing
//            hangs, and counts unclaimed transactions for debug.
// Ports    : clk, reset (sync, active-low)
//            proc_packet_w2e_wsti  - wr/rdrq from last tile
//            proc_packet_e2w_wsto  - poison rdrs, wr/rdrq tied 0
//            if_cfg_wst_s          - glb cfg slave (AXI widths)
//            if_sram_cfg_wst_s     - sram cfg slave (GLB/CGRA widths)
//            strm_packet_e2w_wsto, pc_packet_e2w_wsto - tied 0
//            err_clr, unmapped_proc_wr_cnt, unmapped_proc_rd_cnt,
//            unmapped_cfg_cnt, err_flag
// Revision : 1.0 - initial release
// ============================================================================
module glb_dummy_end
   import glb_dummy_end_pkg::*;
#(
   parameter int RD_LATENCY = 2,    // legal 1..4
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  packet_t              proc_packet_w2e_wsti,
   output packet_t              proc_packet_e2w_wsto,
   cfg_ifc.slave                if_cfg_wst_s,
   cfg_ifc.slave                if_sram_cfg_wst_s,
   output packet_t              strm_packet_e2w_wsto,
   output rd_packet_t           pc_packet_e2w_wsto,
   input  logic                 err_clr,
   output logic [CNT_WIDTH-1:0] unmapped_proc_wr_cnt,
   output logic [CNT_WIDTH-1:0] unmapped_proc_rd_cnt,
   output logic [CNT_WIDTH-1:0] unmapped_cfg_cnt,
   output logic                 err_flag
);

   localparam logic [BANK_DATA_WIDTH-1:0] PROC_POISON =
      {(BANK_DATA_WIDTH/16){PROC_POISON_WORD}};
   localparam logic [AXI_DATA_WIDTH-1:0] CFG_POISON =
      CFG_POISON_WORD[AXI_DATA_WIDTH-1:0];
   localparam logic [CGRA_CFG_DATA_WIDTH-1:0] SRAM_POISON =
      CFG_POISON_WORD[CGRA_CFG_DATA_WIDTH-1:0];

   logic proc_wr, proc_rd;
   logic [3:0] cfg_events;
   logic any_event;

   assign proc_wr    = proc_packet_w2e_wsti.wr.wr_en;
   assign proc_rd    = proc_packet_w2e_wsti.rdrq.rd_en;
   assign cfg_events = {if_cfg_wst_s.wr_en, if_cfg_wst_s.rd_en,
                        if_sram_cfg_wst_s.wr_en, if_sram_cfg_wst_s.rd_en};
   assign any_event  = proc_wr | proc_rd | (|cfg_events);

   // ---------------- proc read poison pipe ----------------
   // Valid-only shift pipe; bit RD_LATENCY-1 is the registered rdrs valid.
   logic [RD_LATENCY-1:0]      pipe_q, pipe_d;
   logic [BANK_DATA_WIDTH-1:0] rdrs_data_q, rdrs_data_d;

   generate
      if (RD_LATENCY == 1) begin : g_pipe_single
         assign pipe_d = proc_rd;
      end else begin : g_pipe_multi
         assign pipe_d = {pipe_q[RD_LATENCY-2:0], proc_rd};
      end
   endgenerate

   // Data register tracks the valid bit so rd_data is 0 whenever invalid.
   assign rdrs_data_d = pipe_d[RD_LATENCY-1] ? PROC_POISON : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe_q      <= '0;
         rdrs_data_q <= '0;
      end else begin
         pipe_q      <= pipe_d;
         rdrs_data_q <= rdrs_data_d;
      end
   end

   always_comb begin
      proc_packet_e2w_wsto                    = '0;
      proc_packet_e2w_wsto.rdrs.rd_data       = rdrs_data_q;
      proc_packet_e2w_wsto.rdrs.rd_data_valid = pipe_q[RD_LATENCY-1];
   end

   assign strm_packet_e2w_wsto = '0;
   assign pc_packet_e2w_wsto   = '0;

   // ---------------- cfg / sram cfg poison responses ----------------
   // rd_clk_en is deliberately ignored: any rd_en gets a one-cycle answer.
   logic [AXI_DATA_WIDTH-1:0]      cfg_rd_data_q;
   logic                           cfg_rd_valid_q;
   logic [CGRA_CFG_DATA_WIDTH-1:0] sram_rd_data_q;
   logic                           sram_rd_valid_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cfg_rd_data_q   <= '0;
         cfg_rd_valid_q  <= 1'b0;
         sram_rd_data_q  <= '0;
         sram_rd_valid_q <= 1'b0;
      end else begin
         cfg_rd_data_q   <= if_cfg_wst_s.rd_en ? CFG_POISON : '0;
         cfg_rd_valid_q  <= if_cfg_wst_s.rd_en;
         sram_rd_data_q  <= if_sram_cfg_wst_s.rd_en ? SRAM_POISON : '0;
         sram_rd_valid_q <= if_sram_cfg_wst_s.rd_en;
      end
   end

   assign if_cfg_wst_s.rd_data           = cfg_rd_data_q;
   assign if_cfg_wst_s.rd_data_valid     = cfg_rd_valid_q;
   assign if_sram_cfg_wst_s.rd_data      = sram_rd_data_q;
   assign if_sram_cfg_wst_s.rd_data_valid = sram_rd_valid_q;

   // ---------------- counters and sticky error ----------------
   glb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (err_clr),
      .inc_i ({2'b00, proc_wr}),
      .cnt_o (unmapped_proc_wr_cnt)
   );

   glb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (err_clr),
      .inc_i ({2'b00, proc_rd}),
      .cnt_o (unmapped_proc_rd_cnt)
   );

   glb_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cfg_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (err_clr),
      .inc_i (count_ones4(cfg_events)),
      .cnt_o (unmapped_cfg_cnt)
   );

   // A new event beats a coincident clear so the flag never misses one.
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (err_clr)   err_d = 1'b0;
      if (any_event) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err_flag = err_q;

   // Payload fields that a terminus has no use for.
   logic unused_inputs;
   assign unused_inputs = ^{proc_packet_w2e_wsti.wr.wr_strb,
                            proc_packet_w2e_wsti.wr.wr_addr,
                            proc_packet_w2e_wsti.wr.wr_data,
                            proc_packet_w2e_wsti.rdrq.rd_addr,
                            proc_packet_w2e_wsti.rdrs,
                            if_cfg_wst_s.wr_clk_en, if_cfg_wst_s.wr_addr,
                            if_cfg_wst_s.wr_data, if_cfg_wst_s.rd_clk_en,
                            if_cfg_wst_s.rd_addr,
                            if_sram_cfg_wst_s.wr_clk_en, if_sram_cfg_wst_s.wr_addr,
                            if_sram_cfg_wst_s.wr_data, if_sram_cfg_wst_s.rd_clk_en,
                            if_sram_cfg_wst_s.rd_addr};

endmodule
`default_nettype wire
